console_mmio: RTL and testbench

CONSOLE_MMIO -- requirements
Module: console_mmio

---
 rtl/console_mmio_pkg.sv | 18 +
 rtl/byte_fifo.sv | 63 ++++++
 rtl/console_mmio.sv | 92 +++++++++
 tb/tb_console_mmio.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/console_mmio_pkg.sv
// console_mmio_pkg: register map, cursor key and STATUS/DATA bit positions
package console_mmio_pkg;

    typedef enum logic [1:0] {
        REG_DATA   = 2'd0,
        REG_STATUS = 2'd1,
        REG_CURSOR = 2'd2,
        REG_RSVD   = 2'd3
    } reg_e;

    localparam logic [15:0] CURSOR_KEY = 16'hFFFF;

    localparam int DATA_VALID_BIT = 8;
    localparam int STAT_OVF_BIT   = 9;
    localparam int STAT_FULL_BIT  = 8;
    localparam int STAT_CNT_MSB   = 7;

endpackage

// File: rtl/byte_fifo.sv
// byte_fifo: flop-based byte FIFO with simultaneous push/pop, even when full
module byte_fifo #(
    parameter  int DEPTH = 8,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic          pop,
    input  logic [7:0]    din,
    output logic [7:0]    dout,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count
);

    logic [7:0]    mem_q [DEPTH];
    logic [7:0]    mem_d [DEPTH];
    logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_push, do_pop;

    assign empty   = count_q == '0;
    assign full    = count_q == CW'(DEPTH);
    assign dout    = mem_q[rptr_q];
    assign count   = count_q;
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    // next storage, pointers (wrap naturally at power-of-two depth) and occupancy
    always_comb begin
        mem_d   = mem_q;
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        if (do_push) begin
            mem_d[wptr_q] = din;
            wptr_d        = wptr_q + 1'b1;
        end
        if (do_pop)
            rptr_d = rptr_q + 1'b1;
        count_d = count_q + CW'(do_push) - CW'(do_pop);
    end

    // pointer and count registers, cleared by reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    // payload storage needs no reset: count gates every read
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/console_mmio.sv
// console_mmio: memory-mapped keyboard FIFO and text cursor registers
module console_mmio
    import console_mmio_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR  = 32'hA000_0000,
    parameter int          FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        kb_valid,
    input  logic [7:0]  kb_data,
    input  logic [31:0] addr,
    input  logic        re,
    input  logic        we,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        sel,
    output logic [7:0]  cursor_row,
    output logic [7:0]  cursor_col,
    output logic        irq
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    reg_e          off;
    logic [7:0]    head;
    logic          full, empty, pop, rd_status, drop, cur_wr;
    logic [CW-1:0] count;
    logic [7:0]    cnt8;
    logic [31:0]   data_word, status_word;
    logic          ovf_q, ovf_d;
    logic [7:0]    row_q, row_d, col_q, col_d;

    assign sel        = addr[31:4] == BASE_ADDR[31:4];
    assign off        = reg_e'(addr[3:2]);
    assign cnt8       = 8'(count);
    assign pop        = sel && re && off == REG_DATA && !empty;
    assign rd_status  = sel && re && off == REG_STATUS;
    assign drop       = kb_valid && full && !pop;
    assign cur_wr     = sel && we && (off == REG_DATA || off == REG_CURSOR) && wdata[31:16] == CURSOR_KEY;
    assign irq        = !empty;
    assign cursor_row = row_q;
    assign cursor_col = col_q;

    byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (kb_valid),
        .pop   (pop),
        .din   (kb_data),
        .dout  (head),
        .full  (full),
        .empty (empty),
        .count (count)
    );

    // combinational read mux over the register window
    always_comb begin
        data_word                             = '0;
        data_word[7:0]                        = head;
        data_word[DATA_VALID_BIT]             = 1'b1;
        status_word                           = '0;
        status_word[STAT_CNT_MSB:0]           = cnt8;
        status_word[STAT_FULL_BIT]            = full;
        status_word[STAT_OVF_BIT]             = ovf_q;
        rdata = !sel                ? '0 :
                off == REG_DATA     ? (empty ? '0 : data_word) :
                off == REG_STATUS   ? status_word :
                off == REG_CURSOR   ? {16'b0, row_q, col_q} : '0;
    end

    // sticky overflow (a dropped byte beats a STATUS read clear) and keyed cursor load
    always_comb begin
        ovf_d = drop ? 1'b1 : rd_status ? 1'b0 : ovf_q;
        row_d = cur_wr ? wdata[15:8] : row_q;
        col_d = cur_wr ? wdata[7:0]  : col_q;
    end

    // overflow and cursor registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
            row_q <= '0;
            col_q <= '0;
        end else begin
            ovf_q <= ovf_d;
            row_q <= row_d;
            col_q <= col_d;
        end
    end

endmodule

// File: tb/tb_console_mmio.sv
// tb_console_mmio: table vectors, corner sequences and randomized model check for console_mmio
module tb_console_mmio;

    localparam logic [31:0] BASE  = 32'hA000_0000;
    localparam int          DEPTH = 8;

    logic        clk = 1'b0, rst_n = 1'b0, kb_valid = 1'b0, re = 1'b0, we = 1'b0;
    logic [7:0]  kb_data = '0;
    logic [31:0] addr = BASE, wdata = '0;
    logic [31:0] rdata;
    logic        sel, irq;
    logic [7:0]  cursor_row, cursor_col;

    int checks = 0, errors = 0;

    logic [7:0] mq [$];
    logic       m_ovf = 1'b0;
    logic [7:0] m_row = '0, m_col = '0;

    typedef struct packed {
        logic        kv;
        logic [7:0]  kd;
        logic [3:0]  off;
        logic        r;
        logic [31:0] exp_rdata;
        logic        exp_irq;
    } vec_t;

    vec_t tbl [$];

    always #5 clk = ~clk;

    console_mmio dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .kb_valid   (kb_valid),
        .kb_data    (kb_data),
        .addr       (addr),
        .re         (re),
        .we         (we),
        .wdata      (wdata),
        .rdata      (rdata),
        .sel        (sel),
        .cursor_row (cursor_row),
        .cursor_col (cursor_col),
        .irq        (irq)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] m_rdata();
        if (addr[31:4] != BASE[31:4]) return 32'h0;
        case (addr[3:2])
            2'd0:    return mq.size() > 0 ? {23'b0, 1'b1, mq[0]} : 32'h0;
            2'd1:    return {22'b0, m_ovf, mq.size() == DEPTH, 8'(mq.size())};
            2'd2:    return {16'b0, m_row, m_col};
            default: return 32'h0;
        endcase
    endfunction

    task automatic mcheck();
        chk("rdata", rdata, m_rdata());
        chk("sel", 32'(sel), 32'(addr[31:4] == BASE[31:4]));
        chk("irq", 32'(irq), 32'(mq.size() > 0));
        chk("row", 32'(cursor_row), 32'(m_row));
        chk("col", 32'(cursor_col), 32'(m_col));
    endtask

    task automatic model_edge();
        logic hit, popped, stat;
        hit    = addr[31:4] == BASE[31:4];
        popped = hit && re && addr[3:2] == 2'd0 && mq.size() > 0;
        stat   = hit && re && addr[3:2] == 2'd1;
        if (popped) void'(mq.pop_front());
        if (stat) m_ovf = 1'b0;
        if (kb_valid) begin
            if (mq.size() < DEPTH) mq.push_back(kb_data);
            else m_ovf = 1'b1;
        end
        if (hit && we && (addr[3:2] == 2'd0 || addr[3:2] == 2'd2) && wdata[31:16] == 16'hFFFF) begin
            m_row = wdata[15:8];
            m_col = wdata[7:0];
        end
    endtask

    task automatic drive(input logic v, input logic [7:0] d, input logic [31:0] a,
                         input logic r, input logic w, input logic [31:0] wd);
        kb_valid = v; kb_data = d; addr = a; re = r; we = w; wdata = wd;
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic cyc(input logic v, input logic [7:0] d, input logic [31:0] a,
                       input logic r, input logic w, input logic [31:0] wd);
        drive(v, d, a, r, w, wd);
        @(negedge clk);
        mcheck();
        tick();
    endtask

    task automatic model_reset();
        mq.delete();
        m_ovf = 1'b0;
        m_row = '0;
        m_col = '0;
    endtask

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("reset_irq", 32'(irq), 32'h0);
        chk("reset_status", rdata, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        tbl.push_back('{1'b1, 8'h41, 4'h0, 1'b0, 32'h0, 1'b0});
        tbl.push_back('{1'b0, 8'h00, 4'h0, 1'b1, 32'h0000_0141, 1'b1});
        tbl.push_back('{1'b0, 8'h00, 4'h0, 1'b1, 32'h0, 1'b0});
        for (int i = 0; i < 9; i++)
            tbl.push_back('{1'b1, 8'(8'h10 + i), 4'h4, 1'b0, (i == 8 ? 32'h108 : 32'(i)), 1'(i > 0)});
        tbl.push_back('{1'b0, 8'h00, 4'h4, 1'b1, 32'h0000_0308, 1'b1});
        for (int i = 0; i < 8; i++)
            tbl.push_back('{1'b0, 8'h00, 4'h0, 1'b1, 32'(32'h110 + i), 1'b1});
        tbl.push_back('{1'b0, 8'h00, 4'h4, 1'b1, 32'h0, 1'b0});

        foreach (tbl[i]) begin
            drive(tbl[i].kv, tbl[i].kd, BASE + 32'(tbl[i].off), tbl[i].r, 1'b0, 32'h0);
            @(negedge clk);
            chk($sformatf("tbl%0d_rdata", i), rdata, tbl[i].exp_rdata);
            chk($sformatf("tbl%0d_irq", i), 32'(irq), 32'(tbl[i].exp_irq));
            tick();
        end

        // full FIFO: push with simultaneous pop keeps count and sets no overflow
        for (int i = 0; i < 8; i++) cyc(1'b1, 8'(8'h20 + i), BASE, 1'b0, 1'b0, 32'h0);
        drive(1'b1, 8'hAA, BASE, 1'b1, 1'b0, 32'h0);
        @(negedge clk);
        chk("full_pushpop_rdata", rdata, 32'h0000_0120);
        tick();
        drive(1'b0, 8'h00, BASE + 32'h4, 1'b1, 1'b0, 32'h0);
        @(negedge clk);
        chk("full_pushpop_status", rdata, 32'h0000_0108);
        tick();
        for (int i = 0; i < 8; i++) begin
            drive(1'b0, 8'h00, BASE, 1'b1, 1'b0, 32'h0);
            @(negedge clk);
            mcheck();
            if (i == 7) chk("last_is_aa", rdata, 32'h0000_01AA);
            tick();
        end

        // dropped push with simultaneous STATUS read: overflow stays set
        for (int i = 0; i < 8; i++) cyc(1'b1, 8'(8'h30 + i), BASE + 32'h4, 1'b0, 1'b0, 32'h0);
        cyc(1'b1, 8'hEE, BASE + 32'h4, 1'b1, 1'b0, 32'h0);
        drive(1'b0, 8'h00, BASE + 32'h4, 1'b1, 1'b0, 32'h0);
        @(negedge clk);
        chk("ovf_set_wins", rdata, 32'h0000_0308);
        tick();
        for (int i = 0; i < 8; i++) cyc(1'b0, 8'h00, BASE, 1'b1, 1'b0, 32'h0);

        // keyed cursor writes
        cyc(1'b0, 8'h00, BASE, 1'b0, 1'b1, 32'hFFFF_0203);
        chk("cursor_row_set", 32'(cursor_row), 32'h2);
        chk("cursor_col_set", 32'(cursor_col), 32'h3);
        cyc(1'b0, 8'h00, BASE + 32'h8, 1'b0, 1'b1, 32'h1234_0506);
        drive(1'b0, 8'h00, BASE + 32'h8, 1'b1, 1'b0, 32'h0);
        @(negedge clk);
        chk("cursor_read", rdata, 32'h0000_0203);
        tick();
        cyc(1'b0, 8'h00, BASE + 32'hC, 1'b1, 1'b1, 32'hFFFF_0909);

        // out-of-window access with FIFO non-empty
        cyc(1'b1, 8'h66, BASE, 1'b0, 1'b0, 32'h0);
        drive(1'b0, 8'h00, BASE + 32'h10, 1'b1, 1'b1, 32'hFFFF_0909);
        @(negedge clk);
        chk("outside_sel", 32'(sel), 32'h0);
        chk("outside_rdata", rdata, 32'h0);
        tick();
        drive(1'b0, 8'h00, BASE + 32'h4, 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        chk("outside_no_pop", rdata, 32'h0000_0001);
        chk("outside_cursor", {16'h0, cursor_row, cursor_col}, 32'h0000_0203);
        tick();

        // asynchronous reset mid-cycle discards bytes and clears cursor at once
        cyc(1'b1, 8'h67, BASE + 32'h4, 1'b0, 1'b0, 32'h0);
        cyc(1'b1, 8'h68, BASE + 32'h4, 1'b0, 1'b0, 32'h0);
        drive(1'b1, 8'h77, BASE + 32'h4, 1'b0, 1'b0, 32'h0);
        #2;
        chk("pre_rst_count", rdata, 32'h0000_0003);
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("rst_irq", 32'(irq), 32'h0);
        chk("rst_status", rdata, 32'h0);
        chk("rst_cursor", {16'h0, cursor_row, cursor_col}, 32'h0);
        @(posedge clk);
        #1;
        chk("rst_kb_ignored", 32'(irq), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b1, 8'h55, BASE + 32'h4, 1'b0, 1'b0, 32'h0);
        tick();
        drive(1'b0, 8'h00, BASE, 1'b1, 1'b0, 32'h0);
        @(negedge clk);
        chk("first_push_after_rst", rdata, 32'h0000_0155);
        mcheck();
        tick();

        // randomized traffic against the queue model
        for (int n = 0; n < 600; n++) begin
            logic [31:0] a, wd;
            int pick;
            pick = $urandom_range(0, 19);
            a = pick == 19 ? BASE + 32'h10 + 32'($urandom_range(0, 15)) :
                pick == 18 ? 32'($urandom) :
                BASE + 32'(4 * $urandom_range(0, 3)) + 32'($urandom_range(0, 3));
            wd = {($urandom_range(0, 1) == 1 ? 16'hFFFF : 16'($urandom)), 16'($urandom)};
            cyc(1'($urandom_range(0, 9) < 6), 8'($urandom), a,
                1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 3) == 0), wd);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
